// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S RX sample packer.
//   state_e            : packer FSM states (IDLE / PACK / FLUSH)
//   WIDTH_8..WIDTH_32  : cfg_num_bits_i codes (sample width minus one)
//   samples_per_word() : samples packed into one 32-bit word for a given config
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [4:0] WIDTH_8  = 5'd7;
    localparam logic [4:0] WIDTH_16 = 5'd15;
    localparam logic [4:0] WIDTH_24 = 5'd23;
    localparam logic [4:0] WIDTH_32 = 5'd31;

    // Only 8- and 16-bit samples share a word; everything else goes one per word.
    function automatic logic [2:0] samples_per_word(input logic pack_en, input logic [4:0] code);
        logic [2:0] n;
        n = 3'd1;
        if (pack_en) begin
            if (code == WIDTH_8)
                n = 3'd4;
            else if (code == WIDTH_16)
                n = 3'd2;
        end
        return n;
    endfunction

endpackage

// File: rtl/i2s_rx_sample_packer_if.sv
// Interfaces used around the I2S RX sample packer.
//   i2s_rx_fifo_if   : packer <-> word FIFO (push/pop/wdata/rdata/full/empty)
//                      master = packer side, slave = FIFO side
//   i2s_rx_stream_if : 32-bit valid/ready stream (samples in, words out)
//                      master = producer, slave = consumer
interface i2s_rx_fifo_if;
    logic        push;
    logic        pop;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        full;
    logic        empty;

    modport master (output push, pop, wdata, input rdata, full, empty);
    modport slave  (input push, pop, wdata, output rdata, full, empty);
endinterface

interface i2s_rx_stream_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/i2s_rx_word_fifo.sv
// Packed-word FIFO between the packer and the uDMA.
//   clk, rst : clock, asynchronous active-high reset
//   fif      : i2s_rx_fifo_if.slave (push/pop/wdata in, rdata/full/empty out)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// rdata reads 0 while empty so the output bus is clean after reset.
module i2s_rx_word_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    i2s_rx_fifo_if.slave  fif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign fif.empty = (wr_ptr == rd_ptr);
    assign fif.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fif.rdata = fif.empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

    // A pop frees the slot in the same cycle, so push+pop works even when full.
    assign do_pop  = fif.pop & ~fif.empty;
    assign do_push = fif.push & (~fif.full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= fif.wdata;
    end

endmodule

// File: rtl/i2s_rx_sample_packer.sv
// I2S RX sample packer: packs right-justified DSP samples into 32-bit words
// for the uDMA, through a small word FIFO.
//   sck_i, rst_i            : clock, asynchronous active-high reset
//   data_i/valid_i/ready_o  : sample input stream
//   data_o/valid_o/ready_i  : packed word output stream (valid_o = FIFO non-empty)
//   err_o                   : one-cycle pulse (cycle after the drop) per dropped sample
//   cfg_en_i, cfg_pack_en_i, cfg_num_bits_i : enable, packing enable, width code
// Optional build macro I2S_RX_SIGN_EXT_EN: sign-extend 24-bit single-sample
// words from bit 23 instead of zero-filling bits [31:24].
module i2s_rx_sample_packer
    import i2s_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sck_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_pack_en_i,
    input  logic [4:0]  cfg_num_bits_i
);
    state_e      state, state_nxt;
    logic [1:0]  slot, slot_nxt;
    logic [2:0]  n_lat, n_cur;
    logic [4:0]  code_lat, code_cur;
    logic [31:0] acc, acc_nxt;
    logic [31:0] sample_w, lane_bits, word;
    logic        accept, last;

    i2s_rx_fifo_if fif ();

    i2s_rx_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk (sck_i),
        .rst (rst_i),
        .fif (fif)
    );

    assign fif.pop = ready_i;
    assign data_o  = fif.rdata;
    assign valid_o = ~fif.empty;

    assign ready_o = cfg_en_i & ~fif.full & (state == ST_PACK);
    assign accept  = valid_i & ready_o;

    // Config is sampled live at the first slot of a word and held for the rest,
    // so a mid-word change only applies to the next word.
    assign n_cur    = (slot == 2'd0) ? samples_per_word(cfg_pack_en_i, cfg_num_bits_i) : n_lat;
    assign code_cur = (slot == 2'd0) ? cfg_num_bits_i : code_lat;
    assign last     = ({1'b0, slot} == (n_cur - 3'd1));

    always_comb begin
        // Keep only code+1 low bits of the sample.
        sample_w = data_i & (32'hFFFF_FFFF >> (5'd31 - code_cur));
`ifdef I2S_RX_SIGN_EXT_EN
        if (n_cur == 3'd1 && code_cur == WIDTH_24)
            sample_w = {{8{data_i[23]}}, data_i[23:0]};
`endif
        case (n_cur)
            3'd4:    lane_bits = {24'd0, sample_w[7:0]}  << {slot, 3'b000};
            3'd2:    lane_bits = {16'd0, sample_w[15:0]} << {slot[0], 4'b0000};
            default: lane_bits = sample_w;
        endcase
    end

    assign word = acc | lane_bits;

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        acc_nxt   = acc;
        fif.push  = 1'b0;
        fif.wdata = word;
        case (state)
            ST_IDLE: begin
                if (cfg_en_i)
                    state_nxt = ST_PACK;
            end
            ST_PACK: begin
                if (accept) begin
                    if (last) begin
                        fif.push = 1'b1;
                        slot_nxt = 2'd0;
                        acc_nxt  = 32'd0;
                    end else begin
                        slot_nxt = slot + 2'd1;
                        acc_nxt  = word;
                    end
                end else if (!cfg_en_i) begin
                    state_nxt = (slot == 2'd0) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Unused upper lanes of acc are still zero.
                fif.wdata = acc;
                if (!fif.full) begin
                    fif.push  = 1'b1;
                    slot_nxt  = 2'd0;
                    acc_nxt   = 32'd0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            slot     <= 2'd0;
            acc      <= 32'd0;
            n_lat    <= 3'd1;
            code_lat <= WIDTH_32;
            err_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            acc   <= acc_nxt;
            if (accept && slot == 2'd0) begin
                n_lat    <= n_cur;
                code_lat <= code_cur;
            end
            err_o <= valid_i & cfg_en_i & ~ready_o;
        end
    end

endmodule

// File: tb/tb_i2s_rx_sample_packer.sv
// Directed bench for i2s_rx_sample_packer (FIFO_DEPTH = 4).
// Table-driven single-word vectors followed by hand-written sequences for
// mid-word config change, flush, FIFO overflow and mid-word reset.
module tb_i2s_rx_sample_packer;
    import i2s_rx_pkg::*;

    logic       sck_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       err_o;
    logic       cfg_en_i = 1'b0;
    logic       cfg_pack_en_i = 1'b0;
    logic [4:0] cfg_num_bits_i = 5'd7;

    int checks = 0;
    int errors = 0;

    i2s_rx_stream_if in_s ();
    i2s_rx_stream_if out_s ();

    i2s_rx_sample_packer #(.FIFO_DEPTH(4)) dut (
        .sck_i          (sck_i),
        .rst_i          (rst_i),
        .data_i         (in_s.data),
        .valid_i        (in_s.valid),
        .ready_o        (in_s.ready),
        .data_o         (out_s.data),
        .valid_o        (out_s.valid),
        .ready_i        (out_s.ready),
        .err_o          (err_o),
        .cfg_en_i       (cfg_en_i),
        .cfg_pack_en_i  (cfg_pack_en_i),
        .cfg_num_bits_i (cfg_num_bits_i)
    );

    always #5 sck_i = ~sck_i;

    typedef struct {
        logic             pack;
        logic [4:0]       code;
        int               n;
        logic [3:0][31:0] s;
        logic [31:0]      exp;
    } vec_t;

    vec_t vt[9];

    function automatic vec_t mk(input logic pack, input logic [4:0] code, input int n,
                                input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input logic [31:0] exp);
        vec_t v;
        v.pack = pack;
        v.code = code;
        v.n    = n;
        v.s[0] = s0;
        v.s[1] = s1;
        v.s[2] = s2;
        v.s[3] = s3;
        v.exp  = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sck_i);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_s.data  = d;
        in_s.valid = 1'b1;
        tick();
        in_s.valid = 1'b0;
    endtask

    task automatic pop_one();
        out_s.ready = 1'b1;
        tick();
        out_s.ready = 1'b0;
    endtask

    logic [31:0] exp24;
    logic [31:0] exp_w;

    initial begin
`ifdef I2S_RX_SIGN_EXT_EN
        exp24 = 32'hFF80_0001;
`else
        exp24 = 32'h0080_0001;
`endif
        vt[0] = mk(1'b1, 5'd7,  4, 32'h11, 32'h22, 32'h33, 32'h44, 32'h4433_2211);
        vt[1] = mk(1'b1, 5'd15, 2, 32'hAAAA, 32'h5555, 0, 0, 32'h5555_AAAA);
        vt[2] = mk(1'b0, 5'd15, 1, 32'hAAAA, 0, 0, 0, 32'h0000_AAAA);
        vt[3] = mk(1'b0, 5'd15, 1, 32'h5555, 0, 0, 0, 32'h0000_5555);
        vt[4] = mk(1'b1, 5'd23, 1, 32'h0080_0001, 0, 0, 0, exp24);
        vt[5] = mk(1'b1, 5'd31, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF);
        vt[6] = mk(1'b1, 5'd7,  4, 32'h1FF, 32'h2AB, 32'h3CD, 32'h4EF, 32'hEFCD_ABFF);
        vt[7] = mk(1'b1, 5'd15, 2, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 32'hDEF0_5678);
        vt[8] = mk(1'b1, 5'd23, 1, 32'h1234_5678, 0, 0, 0, 32'h0034_5678);

        in_s.data   = 32'd0;
        in_s.valid  = 1'b0;
        out_s.ready = 1'b0;

        // Reset state
        #3;
        check("rst valid_o", {31'd0, out_s.valid}, 32'd0);
        check("rst ready_o", {31'd0, in_s.ready}, 32'd0);
        check("rst err_o",   {31'd0, err_o}, 32'd0);
        check("rst data_o",  out_s.data, 32'd0);
        @(posedge sck_i);
        #1 rst_i = 1'b0;

        cfg_en_i = 1'b1;
        tick();
        check("pack ready_o", {31'd0, in_s.ready}, 32'd1);

        // Table: one word per vector, then drain it
        for (int i = 0; i < 9; i++) begin
            cfg_pack_en_i  = vt[i].pack;
            cfg_num_bits_i = vt[i].code;
            for (int k = 0; k < vt[i].n; k++) begin
                if (k == vt[i].n - 1)
                    check($sformatf("vec%0d valid before last", i), {31'd0, out_s.valid}, 32'd0);
                send(vt[i].s[k]);
            end
            check($sformatf("vec%0d valid_o", i), {31'd0, out_s.valid}, 32'd1);
            check($sformatf("vec%0d data_o", i), out_s.data, vt[i].exp);
            pop_one();
            check($sformatf("vec%0d drained", i), {31'd0, out_s.valid}, 32'd0);
        end

        // Mid-word config change applies from the next word
        cfg_pack_en_i  = 1'b1;
        cfg_num_bits_i = 5'd7;
        send(32'h11);
        cfg_num_bits_i = 5'd15;
        send(32'h22);
        send(32'h33);
        send(32'h44);
        send(32'hAAAA);
        send(32'hBBBB);
        check("cfgchg word0", out_s.data, 32'h4433_2211);
        pop_one();
        check("cfgchg word1", out_s.data, 32'hBBBB_AAAA);
        pop_one();
        check("cfgchg drained", {31'd0, out_s.valid}, 32'd0);

        // Flush of a partial word
        cfg_num_bits_i = 5'd7;
        send(32'h01);
        send(32'h02);
        cfg_en_i = 1'b0;
        tick();
        check("flush not yet pushed", {31'd0, out_s.valid}, 32'd0);
        tick();
        check("flush valid_o", {31'd0, out_s.valid}, 32'd1);
        check("flush data_o", out_s.data, 32'h0000_0201);
        check("flush state", 32'(dut.state), 32'(ST_IDLE));
        check("flush ready_o", {31'd0, in_s.ready}, 32'd0);
        pop_one();

        // Overflow: 16 samples fill 4 words, 17th dropped
        cfg_en_i = 1'b1;
        tick();
        for (int i = 0; i < 16; i++)
            send(32'(i + 1));
        check("ovf ready_o", {31'd0, in_s.ready}, 32'd0);
        check("ovf err before drop", {31'd0, err_o}, 32'd0);
        send(32'h99);
        check("ovf err pulse", {31'd0, err_o}, 32'd1);
        tick();
        check("ovf err cleared", {31'd0, err_o}, 32'd0);
        out_s.ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_w = {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)};
            check($sformatf("ovf word%0d", j), out_s.data, exp_w);
            tick();
        end
        out_s.ready = 1'b0;
        check("ovf drained", {31'd0, out_s.valid}, 32'd0);

        // Reset mid-word with a word pending in the FIFO
        send(32'hA1);
        send(32'hA2);
        send(32'hA3);
        send(32'hA4);
        send(32'hAA);
        check("prerst valid_o", {31'd0, out_s.valid}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst valid_o", {31'd0, out_s.valid}, 32'd0);
        check("midrst data_o",  out_s.data, 32'd0);
        check("midrst ready_o", {31'd0, in_s.ready}, 32'd0);
        check("midrst err_o",   {31'd0, err_o}, 32'd0);
        @(posedge sck_i);
        #1 rst_i = 1'b0;
        tick();
        send(32'h01);
        send(32'h02);
        send(32'h03);
        send(32'h04);
        check("postrst data_o", out_s.data, 32'h0403_0201);
        pop_one();
        check("postrst drained", {31'd0, out_s.valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_sample_packer.md
I2S_RX_SAMPLE_PACKER -- requirements
Module: i2s_rx_sample_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: packed-word FIFO entries, power of two, 2..16.
REQ-002 SHALL have port sck_i, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port data_i, input, 32: right-justified sample from the I2S RX DSP channel.
REQ-005 SHALL have port valid_i, input, 1: data_i holds a sample.
REQ-006 SHALL have port ready_o, output, 1: packer can accept a sample this cycle.
REQ-007 SHALL have port data_o, output, 32: packed word to uDMA.
REQ-008 SHALL have port valid_o, output, 1: data_o valid; high whenever the FIFO is non-empty.
REQ-009 SHALL have port ready_i, input, 1: uDMA accepts data_o.
REQ-010 SHALL have port err_o, output, 1: one-cycle pulse per dropped sample or word.
REQ-011 SHALL have port cfg_en_i, input, 1: enable.
REQ-012 SHALL have port cfg_pack_en_i, input, 1: pack narrow samples; 0 means one sample per word.
REQ-013 SHALL have port cfg_num_bits_i, input, 5: sample width minus 1 (7, 15, 23, 31).

Function
REQ-014 SHALL compute samples per word N as 4 for width code 7, 2 for 15, and 1 for all other codes or when cfg_pack_en_i=0.
REQ-015 SHALL accept a sample when valid_i and ready_o are both high; ready_o = cfg_en_i & ~fifo_full & state==PACK, with no combinational path from ready_i.
REQ-016 SHALL place accepted sample k (0..N-1) of a word at lane k: bits [8k+7:8k] for N=4, [16k+15:16k] for N=2; bits above the sample width are discarded.
REQ-017 SHALL latch N and the width code only when the slot counter is 0; a configuration change mid-word SHALL take effect at the next word.
REQ-018 SHALL push the completed word into the FIFO on the cycle its last sample is accepted; valid_o SHALL rise the next cycle if the FIFO was empty (latency 1).
REQ-019 SHALL implement FSM IDLE->PACK when cfg_en_i=1; PACK->IDLE when cfg_en_i=0 and slot counter=0; PACK->FLUSH when cfg_en_i=0 and slot counter!=0; FLUSH->IDLE after pushing the partial word.
REQ-020 SHALL push the partial word in FLUSH with unused lanes zero, waiting while the FIFO is full; the FIFO SHALL keep draining in IDLE.
REQ-021 SHALL pulse err_o and drop the sample when valid_i=1 and cfg_en_i=1 and ready_o=0.
REQ-022 SHALL allow push and pop in the same cycle at any fill level, including full (occupancy unchanged).
REQ-023 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH using an extra wrap bit for full/empty detection.
REQ-024 SHALL hold data_o stable while valid_o=1 and ready_i=0.

Reset
REQ-025 SHALL, on rst_i=1 (asynchronous, any time including mid-word), set state IDLE, slot counter 0, accumulator 0, FIFO empty, valid_o=0, ready_o=0, err_o=0, data_o=0.

Configuration
REQ-026 SHALL, with macro I2S_RX_SIGN_EXT_EN defined, sign-extend from bit 23 the sample written when width code is 23 (N=1); without it, SHALL zero bits [31:24].
REQ-027 SHALL, with or without I2S_RX_SIGN_EXT_EN, pass width code 31 unchanged and leave packed lanes unaffected.

Structure
REQ-028 SHALL take the FSM state enum, the width-code constants (7/15/23/31) and the N-derivation function from shared package i2s_rx_pkg.
REQ-029 SHALL instantiate the FIFO as sub-module i2s_rx_word_fifo (parameter FIFO_DEPTH, push/pop/full/empty).

Verification
REQ-030 SHALL cover: width 7, pack on, samples 0x11,0x22,0x33,0x44 -> one word 0x44332211, valid_o one cycle after the 4th accept.
REQ-031 SHALL cover: width 15, samples 0xAAAA then 0x5555 -> word 0x5555AAAA; pack off -> words 0x0000AAAA, 0x00005555.
REQ-032 SHALL cover: width 23, sample 0x800001 -> 0xFF800001 with I2S_RX_SIGN_EXT_EN, 0x00800001 without.
REQ-033 SHALL cover: width 7, two samples 0x01,0x02 then cfg_en_i=0 -> FLUSH pushes 0x00000201, state IDLE.
REQ-034 SHALL cover: ready_i=0, FIFO_DEPTH=4, 17 width-7 samples -> 4 words stored, ready_o=0, err_o pulse on the 17th; release ready_i -> 4 words in order.
REQ-035 SHALL cover: rst_i pulse mid-word -> all outputs 0 immediately; next word starts at lane 0.
